pre_if_stage: RTL and testbench

Pre-IF stage of the five-stage pipeline: owns the fetch PC, issues instruction-SRAM reads and hands the fetched PC/instruction pair to the IF stage. It has two jobs. It redirects fetch on taken branches, including branches that arrive while IF is stalled. It also holds a returned instruction word in a one-entry buffer when IF cannot consume it, so no SRAM read data is lost during back-pressure.

---
 rtl/pre_if_stage_pkg.sv | 17 +
 rtl/pre_if_stage_skid_buf.sv | 42 ++++
 rtl/pre_if_stage.sv | 77 +++++++
 tb/tb_pre_if_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pre_if_stage_pkg.sv
// Shared constants and types for the pre-IF fetch stage.
package pre_if_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] INST_NOP = 32'h03400000;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pre_if_stage_skid_buf.sv
// One-entry instruction buffer: holds a returned SRAM word while IF cannot consume it.
module inst_skid_buf
  import pre_if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd_pending,
  input  logic        i_drain,
  input  logic        i_flush,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_inst,
  output logic        o_full
);

  buf_state_e  r_state;
  logic [31:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
      r_data  <= INST_NOP;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          // Data returns with nobody to take it and no redirect killing it.
          if (i_rd_pending && !i_drain && !i_flush) begin
            r_state <= BUF_FULL;
            r_data  <= i_rdata;
          end
        end
        BUF_FULL: begin
          if (i_drain || i_flush) r_state <= BUF_EMPTY;
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

  assign o_full = (r_state == BUF_FULL);
  assign o_inst = o_full ? r_data : i_rdata;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: fetch PC, branch redirect (including during stalls) and SRAM read issue.
module pre_if_stage
  import pre_if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allow_in,
  input  logic        fs_to_ds_go,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] inst_sram_rdata,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic        to_fs_valid,
  output logic [31:0] pc,
  output logic [31:0] fs_inst,
  output logic        br_taken_cancel
);

  logic        r_ps_valid;
  logic [31:0] r_pc;
  logic        r_rd_pending;
  logic        r_br_pending;
  logic [31:0] r_br_pend_target;

  logic        w_issue;
  logic [31:0] w_nextpc;
  logic        w_buf_full;

  always_comb begin
    w_issue = r_ps_valid && fs_allow_in;
    // An older redirect held across a stall outranks a fresh branch.
    if (r_br_pending)  w_nextpc = r_br_pend_target;
    else if (br_taken) w_nextpc = word_align(br_target);
    else               w_nextpc = r_pc + PC_STEP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ps_valid       <= 1'b0;
      r_pc             <= RESET_PC - PC_STEP;
      r_rd_pending     <= 1'b0;
      r_br_pending     <= 1'b0;
      r_br_pend_target <= '0;
    end else begin
      r_ps_valid   <= 1'b1;
      r_rd_pending <= w_issue;
      if (w_issue) begin
        r_pc         <= w_nextpc;
        r_br_pending <= 1'b0;
      end else if (br_taken && !r_br_pending) begin
        r_br_pending     <= 1'b1;
        r_br_pend_target <= word_align(br_target);
      end
    end
  end

  inst_skid_buf u_skid_buf (
    .clk          (clk),
    .rst_n        (reset),
    .i_rd_pending (r_rd_pending),
    .i_drain      (fs_to_ds_go),
    .i_flush      (br_taken),
    .i_rdata      (inst_sram_rdata),
    .o_inst       (fs_inst),
    .o_full       (w_buf_full)
  );

  assign inst_sram_en    = w_issue;
  assign inst_sram_we    = '0;
  assign inst_sram_addr  = w_nextpc;
  assign to_fs_valid     = r_ps_valid;
  assign pc              = r_pc;
  assign br_taken_cancel = br_taken;

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed + randomized bench for pre_if_stage against a transaction-level fetch model.
module tb_pre_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fs_allow_in = 1'b0;
  logic        fs_to_ds_go = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] inst_sram_rdata = '0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic        to_fs_valid;
  logic [31:0] pc;
  logic [31:0] fs_inst;
  logic        br_taken_cancel;

  always #5 clk = ~clk;

  pre_if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allow_in     (fs_allow_in),
    .fs_to_ds_go     (fs_to_ds_go),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .to_fs_valid     (to_fs_valid),
    .pc              (pc),
    .fs_inst         (fs_inst),
    .br_taken_cancel (br_taken_cancel)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: fetch PC, queued redirect, in-flight flag, queued buffered word.
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_pend_q[$];
  bit          m_inflight;
  logic [31:0] m_buf_q[$];

  logic        last_en;
  logic        last_cancel;
  logic [31:0] last_addr;
  logic [31:0] last_pc;
  logic [31:0] last_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1c000010) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic a, input logic g, input logic b, input logic [31:0] t);
    logic        e_en;
    logic [31:0] e_next;
    logic [31:0] e_inst;
    fs_allow_in = a;
    fs_to_ds_go = g;
    br_taken    = b;
    br_target   = t;
    #1;
    e_en = m_valid && a;
    if (m_pend_q.size() != 0) e_next = m_pend_q[0];
    else if (b)               e_next = {t[31:2], 2'b00};
    else                      e_next = m_pc + 32'd4;
    if (m_buf_q.size() != 0) e_inst = m_buf_q[0];
    else if (m_inflight)     e_inst = mem(m_pc);
    else                     e_inst = inst_sram_rdata;
    chk("en", {31'b0, inst_sram_en}, {31'b0, e_en});
    if (e_en) chk("addr", inst_sram_addr, e_next);
    chk("we", {28'b0, inst_sram_we}, 32'd0);
    chk("valid", {31'b0, to_fs_valid}, {31'b0, m_valid});
    chk("pc", pc, m_pc);
    chk("inst", fs_inst, e_inst);
    chk("cancel", {31'b0, br_taken_cancel}, {31'b0, b});
    last_en     = inst_sram_en;
    last_cancel = br_taken_cancel;
    last_addr   = inst_sram_addr;
    last_pc     = pc;
    last_inst   = fs_inst;
    @(posedge clk);
    if (b || g) m_buf_q.delete();
    else if (m_inflight && m_buf_q.size() == 0) m_buf_q.push_back(mem(m_pc));
    if (e_en) begin
      m_pc = e_next;
      m_pend_q.delete();
    end else if (b && m_pend_q.size() == 0) begin
      m_pend_q.push_back({t[31:2], 2'b00});
    end
    m_inflight = e_en;
    m_valid    = 1'b1;
    #1 inst_sram_rdata = e_en ? mem(e_next) : $urandom;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_en", {31'b0, inst_sram_en}, 32'd0);
    chk("rst_valid", {31'b0, to_fs_valid}, 32'd0);
    chk("rst_pc", pc, 32'h1bfffffc);
    chk("rst_inst", fs_inst, inst_sram_rdata);
    chk("rst_cancel", {31'b0, br_taken_cancel}, {31'b0, br_taken});
    m_valid    = 1'b0;
    m_pc       = 32'h1bfffffc;
    m_inflight = 1'b0;
    m_pend_q.delete();
    m_buf_q.delete();
    @(posedge clk);
    #1 inst_sram_rdata = $urandom;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic a, g, b;
    logic [31:0] t;
    #2;
    do_reset();

    step(1, 0, 0, 0);
    chk("tp_first_no_en", {31'b0, last_en}, 32'd0);
    step(1, 1, 0, 0);
    chk("tp_addr0", last_addr, 32'h1c000000);
    step(1, 1, 0, 0);
    chk("tp_addr1", last_addr, 32'h1c000004);
    chk("tp_pc0", last_pc, 32'h1c000000);
    chk("tp_inst0", last_inst, mem(32'h1c000000));
    step(1, 1, 0, 0);
    chk("tp_addr2", last_addr, 32'h1c000008);
    chk("tp_pc1", last_pc, 32'h1c000004);

    step(1, 1, 1, 32'h1c000100);
    chk("tp_br_addr", last_addr, 32'h1c000100);
    chk("tp_br_cancel", {31'b0, last_cancel}, 32'd1);
    step(1, 1, 0, 0);
    chk("tp_br_pc", last_pc, 32'h1c000100);

    step(0, 1, 1, 32'h1c000200);
    chk("tp_stall_en0", {31'b0, last_en}, 32'd0);
    step(0, 0, 0, 0);
    chk("tp_stall_en1", {31'b0, last_en}, 32'd0);
    step(0, 0, 0, 0);
    chk("tp_stall_en2", {31'b0, last_en}, 32'd0);
    step(1, 1, 0, 0);
    chk("tp_stall_redirect", last_addr, 32'h1c000200);

    step(1, 1, 1, 32'h1c000010);
    chk("tp_buf_addr", last_addr, 32'h1c000010);
    step(0, 0, 0, 0);
    chk("tp_buf_ret", last_inst, 32'hDEADBEEF);
    step(0, 0, 0, 0);
    chk("tp_buf_hold", last_inst, 32'hDEADBEEF);
    step(0, 1, 0, 0);
    chk("tp_buf_drain", last_inst, 32'hDEADBEEF);
    step(1, 1, 0, 0);
    chk("tp_buf_next", last_addr, 32'h1c000014);

    step(1, 1, 1, 32'hfffffffc);
    chk("tp_wrap_br", last_addr, 32'hfffffffc);
    step(1, 1, 0, 0);
    chk("tp_wrap", last_addr, 32'h00000000);
    step(1, 1, 1, 32'h1c000103);
    chk("tp_align", last_addr, 32'h1c000100);

    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("tp_rst_buf_restart", last_addr, 32'h1c000000);

    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h1c000300);
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("tp_rst_br_restart", last_addr, 32'h1c000000);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      a = ($urandom_range(0, 3) != 0);
      g = $urandom_range(0, 1) != 0;
      b = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 1) != 0) ? (32'h1c000000 | ($urandom & 32'h0000ffff)) : $urandom;
      if (m_buf_q.size() != 0 || (m_inflight && !g)) a = 1'b0;
      step(a, g, b, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
